// File: rtl/sr_ff.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff
// Description : Clocked set/reset flip-flop bank. Each bit of Q is set by S,
//               cleared by R and held otherwise, updated on the rising clock
//               edge. The S=R=1 conflict is resolved per INVALID_MODE, and the
//               conflict is reported on a registered 'invalid' flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH        - number of independent SR bits
//   RESET_VAL    - value loaded into Q while rst is low
//   INVALID_MODE - S=R=1 action: 0 reset-dominant, 1 set-dominant, 2 hold,
//                  3 toggle; any other value behaves as 0
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous reset, active-low
//   S       in   WIDTH  per-bit set request
//   R       in   WIDTH  per-bit reset request
//   Q       out  WIDTH  registered state
//   Q_n     out  WIDTH  bitwise complement of Q
//   invalid out  1      high for one cycle after an edge with any S=R=1 bit
// ============================================================================
module sr_ff #(
  parameter int               WIDTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             invalid
);

  localparam logic [1:0] c_MODE_RST    = 2'd0;
  localparam logic [1:0] c_MODE_SET    = 2'd1;
  localparam logic [1:0] c_MODE_HOLD   = 2'd2;
  localparam logic [1:0] c_MODE_TOGGLE = 2'd3;

  // Out-of-range modes collapse to reset-dominant.
  localparam logic [1:0] c_MODE = (INVALID_MODE >= 0 && INVALID_MODE <= 3) ?
                                  2'(INVALID_MODE) : c_MODE_RST;

  logic [WIDTH-1:0] w_q;
  logic             r_invalid;

  // Each bit lives in its own register so the bits stay fully independent.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic r_bit;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_bit <= RESET_VAL[i];
        end else begin
          case ({S[i], R[i]})
            2'b01:   r_bit <= 1'b0;
            2'b10:   r_bit <= 1'b1;
            2'b11: begin
              case (c_MODE)
                c_MODE_SET:    r_bit <= 1'b1;
                c_MODE_HOLD:   r_bit <= r_bit;
                c_MODE_TOGGLE: r_bit <= ~r_bit;
                default:       r_bit <= 1'b0;
              endcase
            end
            default: r_bit <= r_bit;
          endcase
        end
      end

      assign w_q[i] = r_bit;
    end
  endgenerate

  // Conflict flag is flagged regardless of how the conflict was resolved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= |(S & R);
    end
  end

  // Q_n is derived from the same register as Q so the two can never disagree.
  assign Q       = w_q;
  assign Q_n     = ~w_q;
  assign invalid = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_ff
// Description : Scoreboard bench for sr_ff. Stimulus pushes hand-computed
//               expectations into a queue; a monitor pops and compares them
//               on the falling clock edge, or immediately for asynchronous
//               reset checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ff;

  logic clk;
  logic rst;

  // Instances 0..5 are single-bit: 0 default, 1..4 modes 0..3, 5 mode 7.
  logic [5:0] s1, r1, q1, qn1, inv1;
  logic [3:0] sw, rw, qw, qnw;
  logic       invw;

  sr_ff u_def (.clk(clk), .rst(rst), .S(s1[0]), .R(r1[0]), .Q(q1[0]), .Q_n(qn1[0]), .invalid(inv1[0]));
  sr_ff #(.INVALID_MODE(0)) u_m0 (.clk(clk), .rst(rst), .S(s1[1]), .R(r1[1]), .Q(q1[1]), .Q_n(qn1[1]), .invalid(inv1[1]));
  sr_ff #(.INVALID_MODE(1)) u_m1 (.clk(clk), .rst(rst), .S(s1[2]), .R(r1[2]), .Q(q1[2]), .Q_n(qn1[2]), .invalid(inv1[2]));
  sr_ff #(.INVALID_MODE(2)) u_m2 (.clk(clk), .rst(rst), .S(s1[3]), .R(r1[3]), .Q(q1[3]), .Q_n(qn1[3]), .invalid(inv1[3]));
  sr_ff #(.INVALID_MODE(3)) u_m3 (.clk(clk), .rst(rst), .S(s1[4]), .R(r1[4]), .Q(q1[4]), .Q_n(qn1[4]), .invalid(inv1[4]));
  sr_ff #(.INVALID_MODE(7)) u_m7 (.clk(clk), .rst(rst), .S(s1[5]), .R(r1[5]), .Q(q1[5]), .Q_n(qn1[5]), .invalid(inv1[5]));
  sr_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) u_wide (
    .clk(clk), .rst(rst), .S(sw), .R(rw), .Q(qw), .Q_n(qnw), .invalid(invw)
  );

  localparam int c_WIDE = 6;

  typedef struct {
    int         id;
    logic [3:0] q;
    logic       inv;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  event chk_now;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- monitor
  task automatic drain();
    exp_t       e;
    logic [3:0] aq, aqn, mask;
    logic       ainv;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.id == c_WIDE) begin
        aq = qw; aqn = qnw; ainv = invw; mask = 4'b1111;
      end else begin
        aq = {3'b000, q1[e.id]}; aqn = {3'b000, qn1[e.id]};
        ainv = inv1[e.id]; mask = 4'b0001;
      end
      vectors++;
      if ((aq & mask) !== (e.q & mask) || (aqn & mask) !== (~e.q & mask) ||
          ainv !== e.inv) begin
        miscompares++;
        $display("FAIL %s (inst %0d): got Q=%b Q_n=%b invalid=%b, want Q=%b Q_n=%b invalid=%b",
                 e.name, e.id, aq & mask, aqn & mask, ainv,
                 e.q & mask, ~e.q & mask, e.inv);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or chk_now);
      drain();
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic push(input int id, input logic [3:0] q, input logic inv, input string name);
    exp_t e;
    e.id = id; e.q = q; e.inv = inv; e.name = name;
    sb.push_back(e);
  endtask

  // Drive inputs just after the falling edge, then advance past the next
  // rising edge so expectations pushed afterwards describe that edge.
  task automatic step(input logic [5:0] s, input logic [5:0] r,
                      input logic [3:0] ws, input logic [3:0] wr);
    @(negedge clk);
    #1;
    s1 = s; r1 = r; sw = ws; rw = wr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    s1 = '1; r1 = '0; sw = 4'b1111; rw = 4'b0000;

    // Reset held across three edges with S asserted.
    for (int k = 0; k < 3; k++) begin
      step(6'b111111, 6'b000000, 4'b1111, 4'b0000);
      push(0, 4'b0000, 1'b0, "reset_hold");
      push(c_WIDE, 4'b1010, 1'b0, "wide_reset");
    end

    // Release between edges: no change until the next rising edge.
    @(negedge clk);
    #1;
    s1 = '0; r1 = '0; sw = '0; rw = '0;
    rst = 1'b1;
    #1;
    push(0, 4'b0000, 1'b0, "release_no_change");
    -> chk_now;

    // Basic sequence on the default instance.
    step(6'b000000, 6'b000000, 4'b0, 4'b0); push(0, 4'b0000, 1'b0, "seq_00");
    step(6'b000000, 6'b000001, 4'b0, 4'b0); push(0, 4'b0000, 1'b0, "seq_01");
    step(6'b000001, 6'b000000, 4'b0, 4'b0); push(0, 4'b0001, 1'b0, "seq_10");
    step(6'b000000, 6'b000000, 4'b0, 4'b0); push(0, 4'b0001, 1'b0, "seq_hold");
    step(6'b000001, 6'b000001, 4'b0, 4'b0); push(0, 4'b0000, 1'b1, "seq_11");
    step(6'b000000, 6'b000000, 4'b0, 4'b0); push(0, 4'b0000, 1'b0, "seq_clear_inv");

    // INVALID_MODE sweep: set all mode instances, then two conflicting edges.
    step(6'b111110, 6'b000000, 4'b0, 4'b0);
    for (int id = 1; id <= 5; id++) push(id, 4'b0001, 1'b0, "mode_preset");
    step(6'b111110, 6'b111110, 4'b0, 4'b0);
    push(1, 4'b0000, 1'b1, "mode0_first");
    push(2, 4'b0001, 1'b1, "mode1_first");
    push(3, 4'b0001, 1'b1, "mode2_first");
    push(4, 4'b0000, 1'b1, "mode3_first");
    push(5, 4'b0000, 1'b1, "mode7_first");
    step(6'b111110, 6'b111110, 4'b0, 4'b0);
    push(1, 4'b0000, 1'b1, "mode0_second");
    push(2, 4'b0001, 1'b1, "mode1_second");
    push(3, 4'b0001, 1'b1, "mode2_second");
    push(4, 4'b0001, 1'b1, "mode3_second");
    push(5, 4'b0000, 1'b1, "mode7_second");
    step(6'b000000, 6'b000000, 4'b0, 4'b0);
    push(4, 4'b0001, 1'b0, "mode3_inv_drop");

    // Asynchronous reset between edges.
    step(6'b000001, 6'b000000, 4'b0, 4'b0); push(0, 4'b0001, 1'b0, "async_preset");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push(0, 4'b0000, 1'b0, "async_immediate");
    push(c_WIDE, 4'b1010, 1'b0, "wide_async_immediate");
    -> chk_now;
    step(6'b000001, 6'b000000, 4'b1111, 4'b0000);
    push(0, 4'b0000, 1'b0, "async_hold_s");
    @(negedge clk);
    #1;
    s1 = '0; r1 = '0; sw = '0; rw = '0;
    rst = 1'b1;

    // Multi-bit bank.
    step(6'b0, 6'b0, 4'b0101, 4'b1000); push(c_WIDE, 4'b0111, 1'b0, "wide_set_clr");
    step(6'b0, 6'b0, 4'b0001, 4'b0001); push(c_WIDE, 4'b0110, 1'b1, "wide_conflict");
    step(6'b0, 6'b0, 4'b0000, 4'b0000); push(c_WIDE, 4'b0110, 1'b0, "wide_hold");

    // Glitch on S between edges must not reach Q.
    step(6'b0, 6'b0, 4'b0, 4'b0); push(0, 4'b0000, 1'b0, "glitch_pre");
    @(negedge clk);
    #1;
    s1[0] = 1'b1;
    #2;
    s1[0] = 1'b0;
    @(posedge clk);
    #1;
    push(0, 4'b0000, 1'b0, "glitch_immune");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion by 100000, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sr_ff.md
Name: sr_ff

Overview:
- Clocked set/reset flip-flop bank: each bit of Q is set by S, cleared by R, held otherwise, updated on the rising clock edge.
- Default WIDTH=1 gives a single classic SR flip-flop; wider instances serve as banks of status/flag bits in control logic.
- Complementary output and an invalid-input flag are provided for downstream checking.

Parameters:
- WIDTH, 1, number of independent SR bits.
- RESET_VAL, 0 (WIDTH bits), value loaded into Q during reset.
- INVALID_MODE, 0, action for a bit with S=1 and R=1 at a clock edge:
  - 0 = reset-dominant (Q<=0)
  - 1 = set-dominant (Q<=1)
  - 2 = hold
  - 3 = toggle

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- S  input  WIDTH  per-bit set request, sampled at posedge clk.
- R  input  WIDTH  per-bit reset request, sampled at posedge clk.
- Q  output  WIDTH  registered state.
- Q_n  output  WIDTH  bitwise complement of Q, always exactly ~Q.
- invalid  output  1  registered flag: 1 for one cycle after any edge where some bit had S=R=1.

Behaviour:
- Reset:
  - rst=0 forces Q=RESET_VAL, Q_n=~RESET_VAL, invalid=0 immediately, independent of clk.
  - Held for as long as rst=0; S and R are ignored.
  - Reset mid-operation overrides any pending update.
- Reset release:
  - rst 0->1 causes no output change by itself.
  - The first posedge clk with rst=1 performs a normal update.
- Per-bit update at posedge clk (rst=1), each bit independent, latency 1 clock:
  - S=0,R=0: Q holds.
  - S=0,R=1: Q<=0.
  - S=1,R=0: Q<=1.
  - S=1,R=1: per INVALID_MODE (default: Q<=0).
- invalid:
  - Set to the OR over all bits of (S & R) at each edge.
  - Registered, so it drops after the next edge with no conflicting bits.
  - Asserted regardless of INVALID_MODE.
- Outputs change only on posedge clk or on reset assertion. No combinational path from S/R to outputs.
- Input changes between edges have no effect; only values at the edge matter.
- Q_n is derived from Q; never let them disagree, including during reset.
- INVALID_MODE values outside 0-3: treat as 0.
- Implementation: one always block per register group, async reset in the sensitivity list (negedge rst), generate loop over bits, parameter-selected invalid handling.

Test Plan:
- Reset: drive rst=0 with S=1,R=0 over 3 clock edges -> Q=0, Q_n=1, invalid=0 throughout. Release rst=1 -> unchanged until next posedge.
- Sequence (WIDTH=1, default params) after reset, SR applied before each posedge: 00 -> Q=0; 01 -> Q=0; 10 -> Q=1; 00 -> Q=1 (hold); 11 -> Q=0 with invalid=1 for that cycle; 00 -> invalid=0, Q=0.
- INVALID_MODE sweep, starting from Q=1 then SR=11:
  - mode 0 -> Q=0
  - mode 1 -> Q=1
  - mode 2 -> Q=1
  - mode 3 -> Q=0; a second 11 edge -> Q=1
  - invalid=1 in all cases.
- Async reset mid-cycle: Q=1, pull rst low between edges -> Q=0 within the same time step, no clock needed. Hold S=1 while in reset -> Q stays 0.
- Multi-bit (WIDTH=4, RESET_VAL=4'b1010): after reset Q=1010. Apply S=0101, R=1000 -> Q=0111, Q_n=1000, invalid=0. Then S=0001, R=0001 -> bit0=0, Q=0110, invalid=1.
- Glitch immunity: pulse S high between edges, low again before posedge -> Q unchanged.
